// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with one alloc per cycle, WB_PORTS
// writeback channels and up to COMMIT_W (1 or 2) in-order retirements.
// A committing branch whose actual next PC differs from its prediction
// raises a registered one-cycle flush that empties the buffer.
// Optional feature macro: ROB_WB_BYPASS_EN (same-cycle wakeup bypass on
// the q1/q2 operand lookups).
module rob_multi_commit #(
    parameter int DEPTH_BIT = 4,
    parameter int WB_PORTS  = 2,
    parameter int COMMIT_W  = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          alloc_valid,
    input  logic                          alloc_done,
    input  logic [31:0]                   alloc_value,
    input  logic [4:0]                    alloc_rd,
    input  logic [1:0]                    alloc_type,
    input  logic [31:0]                   alloc_pc,
    input  logic [31:0]                   alloc_pred_pc,
    output logic [DEPTH_BIT-1:0]          alloc_tag,
    output logic                          full,
    output logic [DEPTH_BIT:0]            count,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*DEPTH_BIT-1:0] wb_tag,
    input  logic [WB_PORTS*32-1:0]        wb_val,
    output logic [COMMIT_W-1:0]           commit_valid,
    output logic [COMMIT_W*5-1:0]         commit_rd,
    output logic [COMMIT_W*32-1:0]        commit_val,
    output logic [COMMIT_W*DEPTH_BIT-1:0] commit_tag,
    output logic [COMMIT_W*2-1:0]         commit_type,
    output logic [DEPTH_BIT-1:0]          head_tag,
    output logic                          head_is_mem,
    input  logic [DEPTH_BIT-1:0]          q1_tag,
    input  logic [DEPTH_BIT-1:0]          q2_tag,
    output logic                          q1_ready,
    output logic                          q2_ready,
    output logic [31:0]                   q1_val,
    output logic [31:0]                   q2_val,
    output logic                          flush,
    output logic [31:0]                   flush_pc
);
    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_LOAD   = 2'd2;
    localparam logic [1:0] T_BRANCH = 2'd3;
    localparam logic [DEPTH_BIT:0]   CNT_ZERO = '0;
    localparam logic [DEPTH_BIT:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_BIT:0]   CNT_TWO  = 2;
    localparam logic [DEPTH_BIT:0]   CNT_FULL = (DEPTH_BIT+1)'(DEPTH);
    localparam logic [DEPTH_BIT-1:0] IDX_ONE  = 1;

    // Control state
    logic [DEPTH_BIT-1:0] head_q, tail_q;
    logic [DEPTH_BIT:0]   count_q;
    logic [DEPTH-1:0]     ready_q, ready_nxt;
    logic                 flush_p1;
    logic [31:0]          flush_pc_p1;

    // Entry payload (no reset; qualified by ready_q and count_q)
    logic [31:0] value_q [DEPTH];
    logic [31:0] pred_q  [DEPTH];
    logic [4:0]  rd_q    [DEPTH];
    logic [1:0]  type_q  [DEPTH];

    // The instruction address is carried by the decoder interface but not
    // needed here: the redirect target is the branch's resolved value.
    logic [31:0] unused_pc;
    assign unused_pc = alloc_pc;

    // An index is occupied when its distance from head is below count.
    function automatic logic occupied(input logic [DEPTH_BIT-1:0] idx,
                                      input logic [DEPTH_BIT-1:0] hd,
                                      input logic [DEPTH_BIT:0]   cnt);
        logic [DEPTH_BIT-1:0] off;
        off = idx - hd;
        return {1'b0, off} < cnt;
    endfunction

    logic active, alloc_fire, fire0, fire1, mis0;
    logic [DEPTH_BIT-1:0] head1;
    logic [DEPTH_BIT:0]   n_commit;
    logic [WB_PORTS-1:0]  wb_en;
    logic [DEPTH_BIT-1:0] wb_tag_a [WB_PORTS];
    logic [31:0]          wb_val_a [WB_PORTS];

    assign active     = rdy_in && !flush_p1;
    assign alloc_fire = active && alloc_valid && (count_q != CNT_FULL);
    assign head1      = head_q + IDX_ONE;

    // Unpack writeback channels; only live (occupied) tags are accepted.
    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_tag_a[p] = wb_tag[p*DEPTH_BIT +: DEPTH_BIT];
            wb_val_a[p] = wb_val[p*32 +: 32];
            wb_en[p]    = active && wb_valid[p] && occupied(wb_tag_a[p], head_q, count_q);
        end
    end

    // Commit slot selection: slot 1 never retires a store/branch and never
    // follows a mispredicting branch in slot 0.
    always_comb begin
        fire0 = active && (count_q != CNT_ZERO) && ready_q[head_q];
        mis0  = fire0 && (type_q[head_q] == T_BRANCH) && (value_q[head_q] != pred_q[head_q]);
        fire1 = (COMMIT_W == 2) && fire0 && (count_q > CNT_ONE) && ready_q[head1] &&
                (type_q[head1] != T_STORE) && (type_q[head1] != T_BRANCH) && !mis0;
        n_commit = fire1 ? CNT_TWO : (fire0 ? CNT_ONE : CNT_ZERO);
    end

    // Next ready bits: writebacks set, retirements clear, alloc initialises.
    always_comb begin
        ready_nxt = ready_q;
        for (int p = 0; p < WB_PORTS; p++)
            if (wb_en[p]) ready_nxt[wb_tag_a[p]] = 1'b1;
        if (fire0) ready_nxt[head_q] = 1'b0;
        if (fire1) ready_nxt[head1]  = 1'b0;
        if (alloc_fire) ready_nxt[tail_q] = alloc_done;
    end

    // Control registers: pointers, count, ready bits and the flush pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ready_q     <= '0;
            flush_p1    <= 1'b0;
            flush_pc_p1 <= '0;
        end else if (rdy_in) begin
            if (flush_p1) begin
                head_q   <= '0;
                tail_q   <= '0;
                count_q  <= '0;
                ready_q  <= '0;
                flush_p1 <= 1'b0;
            end else begin
                head_q  <= head_q + n_commit[DEPTH_BIT-1:0];
                tail_q  <= alloc_fire ? tail_q + IDX_ONE : tail_q;
                count_q <= count_q + (alloc_fire ? CNT_ONE : CNT_ZERO) - n_commit;
                ready_q <= ready_nxt;
                if (mis0) begin
                    flush_p1    <= 1'b1;
                    flush_pc_p1 <= value_q[head_q];
                end
            end
        end
    end

    // Payload writes; later channels overwrite earlier ones on a shared tag.
    always_ff @(posedge clk_in) begin
        for (int p = 0; p < WB_PORTS; p++)
            if (wb_en[p]) value_q[wb_tag_a[p]] <= wb_val_a[p];
        if (alloc_fire) begin
            value_q[tail_q] <= alloc_value;
            pred_q[tail_q]  <= alloc_pred_pc;
            rd_q[tail_q]    <= alloc_rd;
            type_q[tail_q]  <= alloc_type;
        end
    end

    logic                 fire_s [2];
    logic [DEPTH_BIT-1:0] tag_s  [2];
    assign fire_s[0] = fire0;
    assign fire_s[1] = fire1;
    assign tag_s[0]  = head_q;
    assign tag_s[1]  = head1;

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
        assign commit_valid[k]                        = fire_s[k];
        assign commit_tag[k*DEPTH_BIT +: DEPTH_BIT]   = fire_s[k] ? tag_s[k] : '0;
        assign commit_rd[k*5 +: 5]                    = fire_s[k] ? rd_q[tag_s[k]] : '0;
        assign commit_val[k*32 +: 32]                 = fire_s[k] ? value_q[tag_s[k]] : '0;
        assign commit_type[k*2 +: 2]                  = fire_s[k] ? type_q[tag_s[k]] : '0;
    end

    assign alloc_tag   = tail_q;
    assign full        = (count_q == CNT_FULL);
    assign count       = count_q;
    assign head_tag    = head_q;
    assign head_is_mem = (count_q != CNT_ZERO) &&
                         ((type_q[head_q] == T_STORE) || (type_q[head_q] == T_LOAD));
    assign flush       = flush_p1;
    assign flush_pc    = flush_pc_p1;

    logic [DEPTH_BIT-1:0] q_tag_a [2];
    logic                 q_rdy_a [2];
    logic [31:0]          q_val_a [2];
    assign q_tag_a[0] = q1_tag;
    assign q_tag_a[1] = q2_tag;

    // Operand lookup: stored ready entries, optionally overridden by the
    // same-cycle alloc and writebacks (highest channel last, so it wins).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            q_rdy_a[i] = ready_q[q_tag_a[i]];
            q_val_a[i] = ready_q[q_tag_a[i]] ? value_q[q_tag_a[i]] : '0;
`ifdef ROB_WB_BYPASS_EN
            if (alloc_fire && alloc_done && (tail_q == q_tag_a[i])) begin
                q_rdy_a[i] = 1'b1;
                q_val_a[i] = alloc_value;
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_en[p] && (wb_tag_a[p] == q_tag_a[i])) begin
                    q_rdy_a[i] = 1'b1;
                    q_val_a[i] = wb_val_a[p];
                end
            end
`endif
        end
    end

    assign q1_ready = q_rdy_a[0];
    assign q1_val   = q_val_a[0];
    assign q2_ready = q_rdy_a[1];
    assign q2_val   = q_val_a[1];
endmodule
